// File: rtl/h264_quantiser_if.sv
// h264_quantiser_if
//   Coefficient-in / level-out bundle between the core transform, the
//   quantiser and the entropy coder.
//   master : transform / entropy-coder side (drives ENABLE, YNIN, QP, INTRA)
//   slave  : quantiser side (drives VALID, ZOUT, NZVALID, NZCOUNT)
interface h264_quantiser_if #(
  parameter int IW = 14,
  parameter int OW = 13
);
  logic                 ENABLE;
  logic signed [IW-1:0] YNIN;
  logic [5:0]           QP;
  logic                 INTRA;
  logic                 VALID;
  logic signed [OW-1:0] ZOUT;
  logic                 NZVALID;
  logic [4:0]           NZCOUNT;

  modport master (
    output ENABLE, YNIN, QP, INTRA,
    input  VALID, ZOUT, NZVALID, NZCOUNT
  );

  modport slave (
    input  ENABLE, YNIN, QP, INTRA,
    output VALID, ZOUT, NZVALID, NZCOUNT
  );
endinterface

// File: rtl/h264_quantiser.sv
// h264_quantiser
//   Forward scalar quantiser for 4x4 residual blocks. Takes the transform's
//   zigzag coefficient stream and emits quantised levels in the same order,
//   three cycles later, plus a per-block count of nonzero levels.
//   CLK    : clock
//   RESET  : synchronous, active-low reset
//   bus    : slave side of h264_quantiser_if
//            in : ENABLE (strobe), YNIN (coefficient), QP, INTRA
//            out: VALID, ZOUT (level), NZVALID (block done), NZCOUNT
module h264_quantiser #(
  parameter int IW = 14,
  parameter int OW = 13
) (
  input logic              CLK,
  input logic              RESET,
  h264_quantiser_if.slave  bus
);
  // |W| <= 2^(IW-1) and MF < 2^14, so product plus rounding fits IW+14 bits
  localparam int SW = IW + 14;

  // QP -> {QP/6, QP%6}; the loop unrolls to a constant table over 0..51
  function automatic logic [6:0] qp_split(input logic [5:0] q);
    int d;
    d = 0;
    for (int i = 1; i < 9; i++)
      if (int'(q) >= 6 * i) d = i;
    return {4'(d), 3'(int'(q) - 6 * d)};
  endfunction

  // Class A: even row & col, B: odd row & col, C: mixed (zigzag positions)
  function automatic logic [1:0] pos_class(input logic [3:0] i);
    case (i)
      4'd0, 4'd3, 4'd5, 4'd11:  return 2'd0;
      4'd4, 4'd10, 4'd12, 4'd15: return 2'd1;
      default:                  return 2'd2;
    endcase
  endfunction

  function automatic logic [13:0] mf_of(input logic [1:0] c, input logic [2:0] m);
    logic [13:0] r;
    r = 14'd0;
    case (c)
      2'd0: case (m)
              3'd0: r = 14'd13107; 3'd1: r = 14'd11916; 3'd2: r = 14'd10082;
              3'd3: r = 14'd9362;  3'd4: r = 14'd8192;  default: r = 14'd7282;
            endcase
      2'd1: case (m)
              3'd0: r = 14'd5243;  3'd1: r = 14'd4660;  3'd2: r = 14'd4194;
              3'd3: r = 14'd3647;  3'd4: r = 14'd3355;  default: r = 14'd2893;
            endcase
      default: case (m)
              3'd0: r = 14'd8066;  3'd1: r = 14'd7490;  3'd2: r = 14'd6554;
              3'd3: r = 14'd5825;  3'd4: r = 14'd5243;  default: r = 14'd4559;
            endcase
    endcase
    return r;
  endfunction

  // floor(2^(15+qpd)/3); the inter value floor(2^qbits/6) is this halved
  function automatic logic [21:0] f_intra(input logic [3:0] d);
    case (d)
      4'd0: return 22'd10922;
      4'd1: return 22'd21845;
      4'd2: return 22'd43690;
      4'd3: return 22'd87381;
      4'd4: return 22'd174762;
      4'd5: return 22'd349525;
      4'd6: return 22'd699050;
      4'd7: return 22'd1398101;
      default: return 22'd2796202;
    endcase
  endfunction

  logic [3:0]    idx;
  logic [5:0]    qp_hold;
  logic          intra_hold;

  logic [5:0]    qp_sel, qp_c;
  logic          intra_sel;
  logic [6:0]    qp_parts;
  logic [21:0]   f3_c;
  logic [IW-1:0] mag_c;

  // The block's QP/INTRA come straight from the bus on its first coefficient
  assign qp_sel    = (idx == 4'd0) ? bus.QP : qp_hold;
  assign intra_sel = (idx == 4'd0) ? bus.INTRA : intra_hold;
  assign qp_c      = (qp_sel > 6'd51) ? 6'd51 : qp_sel;
  assign qp_parts  = qp_split(qp_c);
  assign f3_c      = f_intra(qp_parts[6:3]);
  // Unsigned IW-bit magnitude, so W = -2^(IW-1) yields 2^(IW-1)
  assign mag_c     = bus.YNIN[IW-1] ? (~bus.YNIN + IW'(1)) : bus.YNIN;

  logic          s1_v, s1_neg, s1_first, s1_last;
  logic [IW-1:0] s1_mag;
  logic [13:0]   s1_mf;
  logic [3:0]    s1_qpd;
  logic [21:0]   s1_f;

  logic          s2_v, s2_neg, s2_first, s2_last;
  logic [SW-1:0] s2_sum;
  logic [3:0]    s2_qpd;

  logic [4:0]    nz_acc;
  logic [OW-1:0] zmag_c, z_c;
  logic [4:0]    nz_ext;

  assign zmag_c = OW'(s2_sum >> (5'd15 + 5'(s2_qpd)));
  assign z_c    = s2_neg ? (~zmag_c + OW'(1)) : zmag_c;
  assign nz_ext = {4'd0, |zmag_c};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      idx         <= 4'd0;
      qp_hold     <= 6'd0;
      intra_hold  <= 1'b0;
      s1_v        <= 1'b0;
      s1_neg      <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_mag      <= '0;
      s1_mf       <= '0;
      s1_qpd      <= '0;
      s1_f        <= '0;
      s2_v        <= 1'b0;
      s2_neg      <= 1'b0;
      s2_first    <= 1'b0;
      s2_last     <= 1'b0;
      s2_sum      <= '0;
      s2_qpd      <= '0;
      nz_acc      <= '0;
      bus.VALID   <= 1'b0;
      bus.ZOUT    <= '0;
      bus.NZVALID <= 1'b0;
      bus.NZCOUNT <= '0;
    end else begin
      s1_v <= bus.ENABLE;
      if (bus.ENABLE) begin
        idx      <= idx + 4'd1;
        s1_mag   <= mag_c;
        s1_neg   <= bus.YNIN[IW-1];
        s1_mf    <= mf_of(pos_class(idx), qp_parts[2:0]);
        s1_qpd   <= qp_parts[6:3];
        s1_f     <= intra_sel ? f3_c : (f3_c >> 1);
        s1_first <= (idx == 4'd0);
        s1_last  <= (idx == 4'd15);
        if (idx == 4'd0) begin
          qp_hold    <= bus.QP;
          intra_hold <= bus.INTRA;
        end
      end

      s2_v     <= s1_v;
      s2_sum   <= SW'(s1_mag) * SW'(s1_mf) + SW'(s1_f);
      s2_neg   <= s1_neg;
      s2_qpd   <= s1_qpd;
      s2_first <= s1_first;
      s2_last  <= s1_last;

      bus.VALID   <= s2_v;
      bus.NZVALID <= s2_v & s2_last;
      if (s2_v) begin
        bus.ZOUT <= z_c;
        nz_acc   <= s2_first ? nz_ext : nz_acc + nz_ext;
        if (s2_last) bus.NZCOUNT <= nz_acc + nz_ext;
      end
    end
  end
endmodule

// File: tb/tb_h264_quantiser.sv
`timescale 1ns/1ps
module tb_h264_quantiser;
  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;

  h264_quantiser_if bus ();

  h264_quantiser dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  typedef struct {
    int z;
    int t;
    bit last;
    int nz;
  } exp_t;

  exp_t zq[$];
  int   checks = 0;
  int   errors = 0;
  int   tb_idx = 0;
  int   blk_qp = 0;
  int   blk_intra = 0;
  int   nz_run = 0;

  int mf_tab [3][6] = '{'{13107, 11916, 10082, 9362, 8192, 7282},
                        '{5243, 4660, 4194, 3647, 3355, 2893},
                        '{8066, 7490, 6554, 5825, 5243, 4559}};

  // Reference quantiser: zigzag -> (row,col) to pick the MF class
  function automatic int ref_level(int w, int qp, int intra, int idx);
    int     row_of [16] = '{0, 0, 1, 2, 1, 0, 0, 1, 2, 3, 3, 2, 1, 2, 3, 3};
    int     col_of [16] = '{0, 1, 0, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 3, 2, 3};
    int     qpc, qpd, qpm, qbits, r, c, cls, aw, mag;
    longint num;
    qpc   = (qp > 51) ? 51 : qp;
    qpd   = qpc / 6;
    qpm   = qpc % 6;
    qbits = 15 + qpd;
    r     = row_of[idx];
    c     = col_of[idx];
    cls   = (r % 2 == 0 && c % 2 == 0) ? 0 : ((r % 2 == 1 && c % 2 == 1) ? 1 : 2);
    aw    = (w < 0) ? -w : w;
    num   = longint'(aw) * mf_tab[cls][qpm] + ((longint'(1) << qbits) / (intra != 0 ? 3 : 6));
    mag   = int'(num >> qbits);
    return (w < 0) ? -mag : mag;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic strobe(int w);
    exp_t e;
    if (tb_idx == 0) begin
      blk_qp    = bus.QP;
      blk_intra = bus.INTRA;
      nz_run    = 0;
    end
    e.z = ref_level(w, blk_qp, blk_intra, tb_idx);
    if (e.z != 0) nz_run++;
    e.t    = cyc + 3;
    e.last = (tb_idx == 15);
    e.nz   = nz_run;
    zq.push_back(e);
    bus.YNIN   = 14'(w);
    bus.ENABLE = 1'b1;
    tb_idx     = (tb_idx + 1) % 16;
    @(negedge CLK);
    bus.ENABLE = 1'b0;
  endtask

  // chg_at < 16 switches QP/INTRA on the bus just before that coefficient
  task automatic run_block(int qp, int intra, int w[16], int gap, int chg_at, int qp2);
    bus.QP    = 6'(qp);
    bus.INTRA = intra[0];
    for (int i = 0; i < 16; i++) begin
      if (i == chg_at) begin
        bus.QP    = 6'(qp2);
        bus.INTRA = ~bus.INTRA;
      end
      strobe(w[i]);
      if (gap != 0 && i % 3 == 1) @(negedge CLK);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.VALID === 1'b1) begin
        checks++;
        assert (zq.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_valid: observed VALID=1 expected no output at cycle %0d", cyc);
        end
        if (zq.size() != 0) begin
          e = zq.pop_front();
          checks++;
          assert (bus.ZOUT === 13'(e.z))
          else begin
            errors++;
            $error("FAIL zout: observed %0d expected %0d", $signed(bus.ZOUT), e.z);
          end
          checks++;
          assert (cyc == e.t)
          else begin
            errors++;
            $error("FAIL latency: observed cycle %0d expected cycle %0d", cyc, e.t);
          end
          checks++;
          assert (bus.NZVALID === e.last)
          else begin
            errors++;
            $error("FAIL nzvalid: observed %b expected %b", bus.NZVALID, e.last);
          end
          if (e.last) begin
            checks++;
            assert (bus.NZCOUNT === 5'(e.nz))
            else begin
              errors++;
              $error("FAIL nzcount: observed %0d expected %0d", bus.NZCOUNT, e.nz);
            end
          end
        end
      end else begin
        checks++;
        assert (bus.VALID === 1'b0 && bus.NZVALID === 1'b0)
        else begin
          errors++;
          $error("FAIL idle: observed VALID=%b NZVALID=%b expected 0/0", bus.VALID, bus.NZVALID);
        end
      end
    end
  endtask

  initial begin
    int w[16];
    int last_nz;

    RESET      = 1'b0;
    bus.ENABLE = 1'b0;
    bus.YNIN   = '0;
    bus.QP     = '0;
    bus.INTRA  = 1'b0;

    fork
      monitor();
    join_none

    repeat (3) @(negedge CLK);
    chk("reset_valid",   32'(bus.VALID),   32'd0);
    chk("reset_zout",    32'(bus.ZOUT),    32'd0);
    chk("reset_nzvalid", 32'(bus.NZVALID), 32'd0);
    chk("reset_nzcount", 32'(bus.NZCOUNT), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);

    // QP 28 intra: idx0 W=1000 -> 15, class-B idx4 W=100 -> 0
    w = '{default: 0};
    w[0] = 1000; w[4] = 100; w[1] = 2500; w[15] = -4000;
    run_block(28, 1, w, 0, 16, 0);
    // Negated: -15, and idx4 stays 0 rather than -0
    w = '{default: 0};
    w[0] = -1000; w[4] = -100; w[7] = -777;
    run_block(28, 1, w, 1, 16, 0);

    // QP 0 extremes, intra and inter rounding, W = -8192
    w = '{default: 0};
    w[0] = 8191; w[5] = -8192; w[9] = 1;
    run_block(0, 1, w, 0, 16, 0);
    run_block(0, 0, w, 1, 16, 0);
    w = '{default: 0};
    w[0] = -8192; w[15] = -8192;
    run_block(0, 1, w, 0, 16, 0);

    // Back-to-back block with exactly three nonzero levels
    w = '{default: 0};
    w[0] = 1000; w[1] = 2000; w[2] = -3000;
    run_block(28, 1, w, 0, 16, 0);

    // QP above 51 clamps; compare against the QP 51 block
    for (int i = 0; i < 16; i++) w[i] = (i * 997) % 8192 - 4096;
    run_block(60, 1, w, 0, 16, 0);
    run_block(51, 1, w, 0, 16, 0);
    run_block(63, 0, w, 1, 16, 0);

    // QP / INTRA changes from idx7 must not touch this block
    for (int i = 0; i < 16; i++) w[i] = 300 * (i + 1) * ((i % 2 == 0) ? 1 : -1);
    run_block(20, 1, w, 1, 7, 2);
    run_block(2, 0, w, 0, 16, 0);

    // Random blocks
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) w[i] = int'($urandom_range(16383)) - 8192;
      run_block(int'($urandom_range(63)), int'($urandom_range(1)), w, b % 2, 16, 0);
    end
    last_nz = nz_run;

    // NZCOUNT holds through idle time
    repeat (8) @(negedge CLK);
    chk("nzcount_hold", 32'(bus.NZCOUNT), 32'(last_nz));

    // Reset after 9 strobes of a block
    bus.QP    = 6'd28;
    bus.INTRA = 1'b1;
    for (int i = 0; i < 9; i++) strobe(1000 + 500 * i);
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_valid",   32'(bus.VALID),   32'd0);
    chk("midrst_zout",    32'(bus.ZOUT),    32'd0);
    chk("midrst_nzvalid", 32'(bus.NZVALID), 32'd0);
    chk("midrst_nzcount", 32'(bus.NZCOUNT), 32'd0);
    chk("midrst_drained", 32'(zq.size()),   32'd0);
    zq.delete();
    tb_idx = 0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    w = '{default: 0};
    w[0] = 5000; w[3] = -6000; w[8] = 40; w[12] = 7000; w[15] = 900;
    run_block(28, 1, w, 0, 16, 0);

    repeat (6) @(negedge CLK);
    chk("queue_empty", 32'(zq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
